restoring_divider4: RTL and testbench

- Sequential unsigned integer divider built as the consumer stage of the 4-bit two's-complement subtract path.
- Performs restoring division, one quotient bit per clock. Each cycle it does a trial subtraction of the divisor from the partial remainder, using the same ~b+1 add structure as the subtract path, and keeps or restores the result.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/restoring_divider4.sv | 111 +++++++++++
 tb/tb_restoring_divider4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider4.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module restoring_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_dividend,
  input  logic [WIDTH-1:0] io_in_divisor,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_quotient,
  output logic [WIDTH-1:0] io_out_remainder,
  output logic             io_out_divByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic             accept;
  logic             div_zero;
  logic [WIDTH:0]   s;
  logic [WIDTH+1:0] t_full;
  logic             fits;

  assign accept   = io_in_valid && io_in_ready;
  assign div_zero = (io_in_divisor == '0);

  // Trial subtraction as s + ~{0,div} + 1; the carry-out says s >= div.
  always_comb begin
    s      = {rem[WIDTH-1:0], quo[WIDTH-1]};
    t_full = {1'b0, s} + {1'b0, ~{1'b0, div}} + (WIDTH + 2)'(1);
    fits   = t_full[WIDTH+1];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default is assigned first so no path through the case leaves
  // state_nxt unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : BUSY;
      BUSY:    if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    if (io_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so a reset mid-operation leaves
  // no stale partial result visible on the outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem <= '0;
      quo <= '0;
      div <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              quo <= '1;
              rem <= {1'b0, io_in_dividend};
              dbz <= 1'b1;
            end else begin
              quo <= io_in_dividend;
              rem <= '0;
              div <= io_in_divisor;
              cnt <= CW'(WIDTH);
              dbz <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem <= fits ? t_full[WIDTH:0] : s;
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_in_ready      = (state == IDLE);
  assign io_out_valid     = (state == DONE);
  assign io_out_quotient  = quo;
  assign io_out_remainder = rem[WIDTH-1:0];
  assign io_out_divByZero = dbz;

  // The extra remainder bit only carries the trial-subtract headroom; after
  // any update the partial remainder fits in WIDTH bits.
  rem_in_range: assert property (@(posedge clock) disable iff (!reset) rem[WIDTH] == 1'b0);

endmodule

// File: tb/tb_restoring_divider4.sv
// Scoreboard bench for restoring_divider4: directed vectors push expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_restoring_divider4;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dbz;
  } res_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_dividend = '0;
  logic [3:0] in_divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_quotient;
  logic [3:0] out_remainder;
  logic       out_dbz;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  res_t exp_q[$];

  restoring_divider4 #(.WIDTH(4)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_valid      (in_valid),
    .io_in_ready      (in_ready),
    .io_in_dividend   (in_dividend),
    .io_in_divisor    (in_divisor),
    .io_out_valid     (out_valid),
    .io_out_ready     (out_ready),
    .io_out_quotient  (out_quotient),
    .io_out_remainder (out_remainder),
    .io_out_divByZero (out_dbz)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
    res_t m;
    if (b == 4'd0) begin
      m.q = 4'hF; m.r = a; m.dbz = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Present a pair, optionally record its expected result, and return #1
  // after the accepting edge; acc_cyc holds that edge's cycle number.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input bit push, input bit keep);
    int budget = 0;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    while (!in_ready && budget < 50) begin
      @(posedge clock); #1;
      budget++;
    end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {23'd0, out_quotient, out_remainder, out_dbz}, 32'hFFFF_FFFF);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("result", {23'd0, out_quotient, out_remainder, out_dbz}, {23'd0, e});
      end
    end
  end

  initial begin
    int a1;
    int budget;

    // Reset held for three cycles.
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_outputs", {23'd0, out_quotient, out_remainder, out_dbz}, 32'd0);

    // 13/3 latency: valid first high WIDTH edges after accept.
    send(4'd13, 4'd3, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock); #1;
      check("lat13_busy", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clock); #1;
    check("lat13_valid", {31'd0, out_valid}, 32'd1);
    check("lat13_value", {23'd0, out_quotient, out_remainder, out_dbz}, {23'd0, 4'd4, 4'd1, 1'b0});
    @(posedge clock); #1;
    check("lat13_in_ready", {31'd0, in_ready}, 32'd1);

    // Boundary values.
    send(4'd15, 4'd1, 1'b1, 1'b0);
    send(4'd2, 4'd7, 1'b1, 1'b0);
    send(4'd15, 4'd15, 1'b1, 1'b0);
    send(4'd0, 4'd5, 1'b1, 1'b0);

    // Divide by zero completes on the accepting edge.
    send(4'd5, 4'd0, 1'b1, 1'b0);
    check("dbz_valid", {31'd0, out_valid}, 32'd1);
    check("dbz_value", {23'd0, out_quotient, out_remainder, out_dbz}, {23'd0, 4'd15, 4'd5, 1'b1});
    @(posedge clock); #1;

    // Backpressure: 10/3 held in DONE for six cycles.
    out_ready = 1'b0;
    send(4'd10, 4'd3, 1'b1, 1'b0);
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    for (int k = 0; k < 6; k++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_value", {23'd0, out_quotient, out_remainder, out_dbz}, {23'd0, 4'd3, 4'd1, 1'b0});
      @(posedge clock); #1;
    end
    out_ready = 1'b1;

    // Back-to-back with valid held: second accept one edge after the drain.
    send(4'd9, 4'd2, 1'b1, 1'b1);
    a1 = acc_cyc;
    send(4'd7, 4'd3, 1'b1, 1'b0);
    check("b2b_spacing", acc_cyc - a1, 32'd6);

    // Reset two edges into BUSY discards the in-flight result.
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(posedge clock); #1;
      budget++;
    end
    send(4'd11, 4'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_outputs", {23'd0, out_quotient, out_remainder, out_dbz}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send(4'd6, 4'd4, 1'b1, 1'b0);

    // Full sweep of all operand pairs.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        send(4'(a), 4'(b), 1'b1, 1'b0);

    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clock); #1;
      budget++;
    end
    check("drain_queue", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
